// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package seq_mul_pkg;

    // Default operand width and the matching product width.
    localparam int DEF_WIDTH = 32;
    localparam int PWIDTH    = 2 * DEF_WIDTH;

    // Control states: waiting for a request, iterating, presenting the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_adder.sv
// Combinational full-width adder for the multiplier accumulator.
// The accumulator never exceeds the product width, so the carry-out is dropped.
module mul_adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/seq_mul_unit.sv
// Sequential unsigned multiplier: one multiplier bit is consumed per clock,
// adding the shifted multiplicand into the accumulator when that bit is set.
// Optional macro SEQ_MUL_EARLY_EXIT_EN: finish as soon as no set multiplier
// bits remain, instead of always running WIDTH iterations.
module seq_mul_unit
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state_q;
    logic [PW-1:0]   acc_q;
    logic [PW-1:0]   mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]   count_q;
    logic            busy_q;
    logic            done_q;
    logic [PW-1:0]   product_q;

    logic [PW-1:0]   sum;
    logic [PW-1:0]   acc_d;
    logic [PW-1:0]   mcand_d;
    logic [WIDTH-1:0] mplier_d;
    logic [CW-1:0]   count_d;
    logic            last_step;

    mul_adder #(
        .W (PW)
    ) u_adder (
        .a_i   (acc_q),
        .b_i   (mcand_q),
        .sum_o (sum)
    );

    // Next values for one shift-and-add iteration and the exit decision.
    always_comb begin
        acc_d    = mplier_q[0] ? sum : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
`ifdef SEQ_MUL_EARLY_EXIT_EN
        last_step = (count_q == LAST) || (mplier_d == '0);
`else
        last_step = (count_q == LAST);
`endif
    end

    // Control FSM with registered handshake outputs and the datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, a};
                        mplier_q <= b;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    count_q  <= count_d;
                    if (last_step) begin
                        product_q <= acc_d;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Self-checking bench for seq_mul_unit (WIDTH=32), randomized against a*b.
module tb_seq_mul_unit;

    localparam int WIDTH = 32;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              busy;
    logic              done;
    logic [2*WIDTH-1:0] product;

    int total = 0;
    int bad   = 0;

    seq_mul_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product: plain arithmetic on widened operands.
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] wx, wy;
        wx = {32'd0, x};
        wy = {32'd0, y};
        return wx * wy;
    endfunction

    // Reference number of CALC cycles for multiplier y.
    function automatic int ref_lat(input logic [31:0] y);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        if (y == 32'd0) return 1;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (y[i]) return i + 1;
        return 1;
`else
        return (y == y) ? WIDTH : WIDTH;
`endif
    endfunction

    // Drive one operation; observe product, latency, done pulses, busy cycles.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input int poke_at,
                          output logic [63:0] prod, output int lat, output int ndone,
                          output int nbusy, output bit tmo);
        prod = '0; lat = -1; ndone = 0; nbusy = 0; tmo = 1'b0;
        a = oa; b = ob; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        if (busy) nbusy++;
        for (int k = 1; k <= WIDTH + 8; k++) begin
            if (k == poke_at) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    prod = product;
                end
            end
        end
        if (lat < 0) tmo = 1'b1;
    endtask

    task automatic test_reset();
        logic [63:0] p; int l, nd, nb; bit t;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, product} !== {2'b00, 64'd0}) begin
            bad++;
            $display("FAIL reset_state: busy=%0b done=%0b product=%h, want 0/0/0", busy, done, product);
        end
        rst_n = 1'b1;
        run_op(32'd2, 32'd3, 0, p, l, nd, nb, t);
        total++;
        if (p !== 64'd6 || t) begin
            bad++;
            $display("FAIL pre_abort_op: product=%0d tmo=%0b, want 6", p, t);
        end
        a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_midcalc_busy: busy=%0b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, product} !== {2'b00, 64'd0}) begin
            bad++;
            $display("FAIL async_abort: busy=%0b done=%0b product=%h, want 0/0/0", busy, done, product);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd3, 32'd4, 0, p, l, nd, nb, t);
        total++;
        if (p !== 64'd12 || l != ref_lat(32'd4) || t) begin
            bad++;
            $display("FAIL after_abort_op: product=%0d lat=%0d, want 12 lat=%0d", p, l, ref_lat(32'd4));
        end
    endtask

    task automatic test_basic();
        logic [63:0] p; int l, nd, nb; bit t;
        run_op(32'd7, 32'd9, 0, p, l, nd, nb, t);
        total++;
        if (p !== 64'd63) begin
            bad++;
            $display("FAIL basic_product: got %0d want 63", p);
        end
        total++;
        if (l != ref_lat(32'd9) || t) begin
            bad++;
            $display("FAIL basic_latency: got %0d want %0d", l, ref_lat(32'd9));
        end
        total++;
        if (nd != 1) begin
            bad++;
            $display("FAIL basic_done_pulses: got %0d want 1", nd);
        end
        total++;
        if (nb != ref_lat(32'd9) + 1) begin
            bad++;
            $display("FAIL basic_busy_cycles: got %0d want %0d", nb, ref_lat(32'd9) + 1);
        end
    endtask

    task automatic test_all_ones();
        logic [63:0] p; int l, nd, nb; bit t;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, p, l, nd, nb, t);
        total++;
        if (p !== 64'hFFFF_FFFE_0000_0001 || l != WIDTH || t) begin
            bad++;
            $display("FAIL all_ones: product=%h lat=%0d, want fffffffe00000001 lat=%0d", p, l, WIDTH);
        end
    endtask

    task automatic test_zero();
        logic [63:0] p; int l, nd, nb; bit t;
        run_op(32'd12345, 32'd0, 0, p, l, nd, nb, t);
        total++;
        if (p !== 64'd0) begin
            bad++;
            $display("FAIL zero_b_product: got %0d want 0", p);
        end
        total++;
        if (l != ref_lat(32'd0) || t) begin
            bad++;
            $display("FAIL zero_b_latency: got %0d want %0d", l, ref_lat(32'd0));
        end
        run_op(32'd0, 32'h8000_0001, 0, p, l, nd, nb, t);
        total++;
        if (p !== 64'd0 || l != WIDTH || t) begin
            bad++;
            $display("FAIL zero_a: product=%0d lat=%0d, want 0 lat=%0d", p, l, WIDTH);
        end
    endtask

    task automatic test_early_exit();
        logic [63:0] p; int l, nd, nb; bit t;
        run_op(32'd6, 32'd5, 0, p, l, nd, nb, t);
        total++;
        if (p !== 64'd30 || l != ref_lat(32'd5) || t) begin
            bad++;
            $display("FAIL six_by_five: product=%0d lat=%0d, want 30 lat=%0d", p, l, ref_lat(32'd5));
        end
    endtask

    task automatic test_ignore_start();
        logic [63:0] p; int l, nd, nb; bit t;
        logic [31:0] xa, xb;
        xa = 32'h8000_0003; xb = 32'h8000_0005;
        run_op(xa, xb, 5, p, l, nd, nb, t);
        total++;
        if (p !== ref_prod(xa, xb) || nd != 1 || t) begin
            bad++;
            $display("FAIL ignore_start: product=%h done_pulses=%0d, want %h and 1", p, nd, ref_prod(xa, xb));
        end
        total++;
        if (product !== ref_prod(xa, xb) || busy !== 1'b0) begin
            bad++;
            $display("FAIL product_held: product=%h busy=%0b, want %h and 0", product, busy, ref_prod(xa, xb));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2;
        logic [63:0] p1, p2;
        int d1, d2;
        a1 = 32'd100; b1 = 32'h8000_0001;
        a2 = $urandom; b2 = $urandom >> $urandom_range(0, 31);
        p1 = '0; p2 = '0; d1 = -1; d2 = -1;
        a = a1; b = b1; start = 1'b1;
        for (int e = 1; e <= 200 && d2 < 0; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = e; p1 = product; a = a2; b = b2;
                end else begin
                    d2 = e; p2 = product; start = 1'b0;
                end
            end
        end
        start = 1'b0;
        total++;
        if (d1 != 1 + ref_lat(b1) || p1 !== ref_prod(a1, b1)) begin
            bad++;
            $display("FAIL b2b_first: edge=%0d product=%h, want edge=%0d %h", d1, p1, 1 + ref_lat(b1), ref_prod(a1, b1));
        end
        total++;
        if (d2 < 0 || d2 - d1 != ref_lat(b2) + 2 || p2 !== ref_prod(a2, b2)) begin
            bad++;
            $display("FAIL b2b_second: gap=%0d product=%h, want gap=%0d %h", d2 - d1, p2, ref_lat(b2) + 2, ref_prod(a2, b2));
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [63:0] p; int l, nd, nb; bit t;
        logic [31:0] ra, rb;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 19) == 0) rb = 32'd0;
            run_op(ra, rb, 0, p, l, nd, nb, t);
            total++;
            if (p !== ref_prod(ra, rb) || nd != 1) begin
                bad++;
                $display("FAIL random_product: %h*%h got %h want %h pulses=%0d", ra, rb, p, ref_prod(ra, rb), nd);
            end
            total++;
            if (l != ref_lat(rb) || t) begin
                bad++;
                $display("FAIL random_latency: b=%h got %0d want %0d", rb, l, ref_lat(rb));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_zero();
        test_early_exit();
        test_ignore_start();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
- Sequential unsigned multiplier using iterative shift-and-add, one multiplier bit per clock.
- It is the repeated-addition counterpart of the repeated-subtraction modulus datapath.
- Combines datapath and control FSM behind a start/done handshake.
- Sits beside the mod datapath in the arithmetic unit; the same top-level sequencer drives both.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
a  input  WIDTH  multiplicand, captured on accepted start
b  input  WIDTH  multiplier, captured on accepted start
busy  output  1  high in CALC and DONE states
done  output  1  one-cycle pulse, high in DONE state
product  output  2*WIDTH  result; valid while done is high, held until next accepted start

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, product=0, internal acc/mcand_sh/mplier/count all 0.
- Reset mid-operation aborts immediately to IDLE with product=0. No partial result is retained.
- Internal registers:
  - acc [2*WIDTH-1:0]
  - mcand_sh [2*WIDTH-1:0]
  - mplier [WIDTH-1:0]
  - count [$clog2(WIDTH)-1:0]
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge: acc<=0, mcand_sh<={0,a}, mplier<=b, count<=0, go to CALC.
  - start=0: remain in IDLE.
  - product is unchanged in both cases.
- CALC, each edge:
  - If mplier[0], acc<=acc+mcand_sh; the add is full 2*WIDTH bits and cannot overflow.
  - mcand_sh<=mcand_sh<<1; mplier<=mplier>>1; count<=count+1.
  - Exit when count==WIDTH-1 (last step). On exit, product<=final acc (including this step's add); go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
- Handshake:
  - start is ignored in CALC and DONE. No queuing.
  - Earliest next accept is the first IDLE cycle after done.
  - start held high continuously yields back-to-back operations, each separated by one IDLE cycle.
- Latency: start accepted at edge T; done high in the cycle following edge T+WIDTH (WIDTH CALC cycles).
- Inputs a/b may change freely after acceptance; they are not re-sampled.
- Boundaries:
  - a=0 or b=0 gives product=0 with full latency.
  - All-ones operands give (2^WIDTH-1)^2 with no truncation.

Optional Feature:
- Macro: SEQ_MUL_EARLY_EXIT_EN.
- Defined: CALC also exits when the post-shift mplier value (mplier>>1) equals 0.
  - b=0 exits after 1 CALC cycle (done after edge T+1).
  - Otherwise exits after msb_index(b)+1 CALC cycles.
  - The product is identical to the non-early result.
- Undefined: fixed WIDTH CALC cycles regardless of operands.

Decomposition:
- Package seq_mul_pkg:
  - state enum (IDLE, CALC, DONE)
  - default WIDTH constant
  - localparam PWIDTH=2*WIDTH
- One sub-module: mul_adder, a combinational 2*WIDTH-bit adder (sum, carry-out unused). It mirrors the team's subtractor block.
- FSM and registers stay in seq_mul_unit.

Test Plan:
- Reset during CALC (assert rst_n=0 at cycle 5 of a 7*9 op) -> busy=0, done=0, product=0 same cycle (async); next start 3*4 -> product=12.
- WIDTH=32, a=7, b=9, start one cycle -> done pulses exactly once in cycle after edge T+32, product=63, busy high for 33 cycles.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001.
- a=12345, b=0 -> product=0.
  - Without macro: done after 32 CALC cycles.
  - With SEQ_MUL_EARLY_EXIT_EN: done after edge T+1.
- start pulsed again during CALC with different operands -> ignored; product equals the first operation's result. With start held high, the second op is accepted in the IDLE cycle after done.
- With SEQ_MUL_EARLY_EXIT_EN, a=6, b=5 -> done after 3 CALC cycles, product=30. Randomized 1000 pairs match a*b in both macro builds.
